ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 2, the RAM address width.
REQ-002 SHALL have parameter DW, default 3, the RAM data width.
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports REQ0/REQ1  input  1  requester 0/1 access request, held until granted.
REQ-006 SHALL have ports WR0/WR1  input  1  requester 0/1 access type: 1 = write, 0 = read.
REQ-007 SHALL have ports A0/A1  input  AW  requester 0/1 address.
REQ-008 SHALL have ports D0/D1  input  DW  requester 0/1 write data.
REQ-009 SHALL have ports GNT0/GNT1  output  1  grant; handshake completes on an edge where REQx and GNTx are both high.
REQ-010 SHALL have ports Q0/Q1  output  DW  read data for requester 0/1.
REQ-011 SHALL have ports QV0/QV1  output  1  read-data-valid strobe for requester 0/1.
REQ-012 SHALL have port CLR_START  input  1  single-cycle request to zero the whole RAM.
REQ-013 SHALL have port CLR_BUSY  output  1  clear in progress.
REQ-014 SHALL have port CLR_DONE  output  1  one-cycle pulse at clear completion.
REQ-015 SHALL have ports RAM_EN, RAM_WR (1), RAM_A (AW), RAM_D (DW)  output  driving the single-port RAM.
REQ-016 SHALL have port RAM_Q  input  DW  RAM read data, valid one cycle after a read enable.

Function
REQ-017 SHALL implement two states: SERVE and CLEAR.
REQ-018 In SERVE, it SHALL grant at most one requester per cycle; GNTx is combinational from REQx, the priority pointer and the state.
REQ-019 If only one REQ is high, that requester SHALL be granted the same cycle.
REQ-020 If both REQs are high, the requester holding priority SHALL be granted.
REQ-021 After every completed handshake, priority SHALL pass to the other requester.
REQ-022 During a grant cycle, RAM_EN=1 and RAM_WR/RAM_A/RAM_D SHALL equal the granted WRx/Ax/Dx; otherwise RAM_EN=0.
REQ-023 For a read handshake, QVx SHALL be high exactly the next cycle, with Qx=RAM_Q in that cycle.
REQ-024 Qx SHALL be don't-care while QVx=0.
REQ-025 A write handshake SHALL produce no QV pulse.
REQ-026 It SHALL sustain one handshake per cycle, including back-to-back handshakes by the same requester.
REQ-027 CLR_START in SERVE SHALL, at the next edge, enter CLEAR, set CLR_BUSY=1 and zero the address counter.
REQ-028 If CLR_START coincides with REQs, CLR_START SHALL win: no grant in that cycle.
REQ-029 In CLEAR, each cycle SHALL drive RAM_EN=1, RAM_WR=1, RAM_D=0 and RAM_A=counter, then increment the counter; GNT0/GNT1 SHALL stay 0.
REQ-030 After the write to address 2^AW-1 (2^AW cycles in CLEAR), it SHALL return to SERVE, CLR_BUSY=0, with CLR_DONE high for one cycle.
REQ-031 The counter SHALL be AW+1 bits wide to detect terminal count without wrap ambiguity.
REQ-032 CLR_START during CLEAR SHALL be ignored.
REQ-033 A pending read QV strobe SHALL still issue in the first CLEAR cycle.
REQ-034 The priority pointer SHALL be unchanged by a clear.

Reset
REQ-035 RST high SHALL immediately force state=SERVE, priority=requester 0, counter=0, QV0=QV1=0, CLR_BUSY=0, CLR_DONE=0.
REQ-036 While RST is high, GNT0=GNT1=0 and RAM_EN=0.
REQ-037 Reset asserted mid-clear SHALL abort the clear with no CLR_DONE; RAM contents are then undefined.

Structure
REQ-038 State encoding (SERVE, CLEAR) and AW/DW defaults SHALL live in the shared package ram_ctrl_pkg.
REQ-039 There SHALL be no sub-module inside ram_arbiter; the top level SHALL instantiate ram (AW, DW) beside it, connecting RAM_* to CLK/A/D/EN/WR/Q.

Verification (AW=2, DW=3, with ram instance)
REQ-040 Single write then read: REQ0 WR0=1 A0=2 D0=5, then REQ0 read A0=2 -> GNT0 each cycle; QV0=1, Q0=5 the cycle after the read grant.
REQ-041 Contention: REQ0 and REQ1 both high and held 4 cycles after reset -> grants alternate 0,1,0,1.
REQ-042 Back-to-back: REQ1 writes A=0..3 D=1..4 on consecutive cycles, then reads A=3 -> 4 grants in 4 cycles; Q1=4.
REQ-043 Clear: fill all 4 addresses with 7, pulse CLR_START together with REQ0 -> no GNT0 that cycle; CLR_BUSY high 4 cycles; CLR_DONE pulse; reads of A=0..3 return 0.
REQ-044 Reset mid-clear: RST asserted in the 2nd CLEAR cycle -> CLR_BUSY, QV and GNT immediately 0; no CLR_DONE; after release, REQ1 is granted the first cycle it requests.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM arbiter: controller state encoding and default geometry.
package ram_ctrl_pkg;

  localparam int AW_DEFAULT = 2;
  localparam int DW_DEFAULT = 3;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram.sv
// Single-port synchronous RAM: write on EN&WR, registered read data one cycle after EN&!WR.
module ram
  import ram_ctrl_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          CLK,
  input  logic          EN,
  input  logic          WR,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];

  // Storage array and read register; Q holds its last read value during writes.
  always_ff @(posedge CLK) begin
    if (EN && WR) begin
      mem_r[A] <= D;
    end else if (EN) begin
      Q <= mem_r[A];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM, with a whole-RAM clear engine.
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WR0,
  input  logic          WR1,
  input  logic [AW-1:0] A0,
  input  logic [AW-1:0] A1,
  input  logic [DW-1:0] D0,
  input  logic [DW-1:0] D1,
  output logic          GNT0,
  output logic          GNT1,
  output logic [DW-1:0] Q0,
  output logic [DW-1:0] Q1,
  output logic          QV0,
  output logic          QV1,
  input  logic          CLR_START,
  output logic          CLR_BUSY,
  output logic          CLR_DONE,
  output logic          RAM_EN,
  output logic          RAM_WR,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_D,
  input  logic [DW-1:0] RAM_Q
);

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_t        state_r;
  logic          prio_r;
  logic [AW:0]   cnt_r;
  logic [AW:0]   cnt_next_s;
  logic          qv0_r;
  logic          qv1_r;
  logic          clr_busy_r;
  logic          clr_done_r;
  logic          serve_s;
  logic          gnt0_s;
  logic          gnt1_s;

  // A clear request pre-empts any grant in the same cycle.
  assign serve_s    = (state_r == SERVE) && !RST && !CLR_START;
  assign gnt0_s     = serve_s && REQ0 && (!REQ1 || !prio_r);
  assign gnt1_s     = serve_s && REQ1 && (!REQ0 || prio_r);
  assign cnt_next_s = cnt_r + CNT_ONE;

  assign GNT0     = gnt0_s;
  assign GNT1     = gnt1_s;
  assign QV0      = qv0_r;
  assign QV1      = qv1_r;
  assign Q0       = RAM_Q;
  assign Q1       = RAM_Q;
  assign CLR_BUSY = clr_busy_r;
  assign CLR_DONE = clr_done_r;

  // RAM port mux: clear writes take the port, otherwise the granted requester drives it.
  always_comb begin
    RAM_EN = 1'b0;
    RAM_WR = 1'b0;
    RAM_A  = '0;
    RAM_D  = '0;
    if (!RST && (state_r == CLEAR)) begin
      RAM_EN = 1'b1;
      RAM_WR = 1'b1;
      RAM_A  = cnt_r[AW-1:0];
      RAM_D  = '0;
    end else if (gnt0_s) begin
      RAM_EN = 1'b1;
      RAM_WR = WR0;
      RAM_A  = A0;
      RAM_D  = D0;
    end else if (gnt1_s) begin
      RAM_EN = 1'b1;
      RAM_WR = WR1;
      RAM_A  = A1;
      RAM_D  = D1;
    end else begin
      RAM_EN = 1'b0;
      RAM_WR = 1'b0;
      RAM_A  = '0;
      RAM_D  = '0;
    end
  end

  // Controller FSM, priority pointer, clear counter and read-valid strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r    <= SERVE;
      prio_r     <= 1'b0;
      cnt_r      <= '0;
      qv0_r      <= 1'b0;
      qv1_r      <= 1'b0;
      clr_busy_r <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      qv0_r      <= gnt0_s && !WR0;
      qv1_r      <= gnt1_s && !WR1;
      clr_done_r <= 1'b0;
      case (state_r)
        SERVE: begin
          if (CLR_START) begin
            state_r    <= CLEAR;
            clr_busy_r <= 1'b1;
            cnt_r      <= '0;
          end else if (gnt0_s) begin
            prio_r <= 1'b1;
          end else if (gnt1_s) begin
            prio_r <= 1'b0;
          end else begin
            prio_r <= prio_r;
          end
        end
        CLEAR: begin
          // The extra counter bit flags the last address without comparing against a wrapped value.
          cnt_r <= cnt_next_s;
          if (cnt_next_s[AW]) begin
            state_r    <= SERVE;
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b1;
          end else begin
            state_r <= CLEAR;
          end
        end
        default: begin
          state_r <= SERVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed vector table for the arbiter plus a randomized run against a behavioural model.
module tb_ram_arbiter;
  import ram_ctrl_pkg::*;

  localparam int AW = 2;
  localparam int DW = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, req0, req1, wr0, wr1, gnt0, gnt1, qv0, qv1;
  logic clr_start, clr_busy, clr_done, ram_en, ram_wr;
  logic [AW-1:0] a0, a1, ram_a;
  logic [DW-1:0] d0, d1, q0, q1, ram_d, ram_q;

  int n_vec = 0;
  int n_err = 0;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .WR0(wr0), .WR1(wr1),
    .A0(a0), .A1(a1), .D0(d0), .D1(d1), .GNT0(gnt0), .GNT1(gnt1),
    .Q0(q0), .Q1(q1), .QV0(qv0), .QV1(qv1), .CLR_START(clr_start),
    .CLR_BUSY(clr_busy), .CLR_DONE(clr_done), .RAM_EN(ram_en), .RAM_WR(ram_wr),
    .RAM_A(ram_a), .RAM_D(ram_d), .RAM_Q(ram_q)
  );

  ram #(.AW(AW), .DW(DW)) u_ram (
    .CLK(clk), .EN(ram_en), .WR(ram_wr), .A(ram_a), .D(ram_d), .Q(ram_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst, clr, op0, a0, d0, op1, a1, d1;
    int g0, g1, qv0, q0, qv1, q1, busy, done, en;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int r, int c, int o0, int x0, int y0, int o1, int x1, int y1,
                              int g0, int g1, int v0, int e0, int v1, int e1,
                              int b, int dn, int en);
    vec_t v;
    v.rst = r; v.clr = c; v.op0 = o0; v.a0 = x0; v.d0 = y0; v.op1 = o1; v.a1 = x1; v.d1 = y1;
    v.g0 = g0; v.g1 = g1; v.qv0 = v0; v.q0 = e0; v.qv1 = v1; v.q1 = e1;
    v.busy = b; v.done = dn; v.en = en;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // op: 0 = idle, 1 = read, 2 = write
  task automatic drive(input int r, input int c, input int o0, input int x0, input int y0,
                       input int o1, input int x1, input int y1);
    rst = r[0];
    clr_start = c[0];
    req0 = (o0 != 0); wr0 = (o0 == 2); a0 = x0[AW-1:0]; d0 = y0[DW-1:0];
    req1 = (o1 != 0); wr1 = (o1 == 2); a1 = x1[AW-1:0]; d1 = y1[DW-1:0];
  endtask

  // Behavioural model state for the random run
  int  m_prio, m_clear_left, m_done, m_q0, m_q1;
  bit  m_qv0, m_qv1;
  int  m_mem [DEPTH];
  bit  m_valid [DEPTH];
  bit  p_req [2];
  bit  p_wr [2];
  int  p_a [2];
  int  p_d [2];

  initial begin
    // rst clr | op0 a0 d0 | op1 a1 d1 || g0 g1 qv0 q0 qv1 q1 busy done en
    vecs.push_back(mk(1,0, 1,0,0, 1,0,0, 0,0,0,-1,0,-1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0,-1,0,-1,0,0,0));
    vecs.push_back(mk(0,0, 2,2,5, 0,0,0, 1,0,0,-1,0,-1,0,0,1));
    vecs.push_back(mk(0,0, 1,2,0, 0,0,0, 1,0,0,-1,0,-1,0,0,1));
    vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,1, 5,0,-1,0,0,0));
    vecs.push_back(mk(1,0, 0,0,0, 0,0,0, 0,0,0,-1,0,-1,0,0,0));
    for (int k = 0; k < 2; k++) begin
      vecs.push_back(mk(0,0, 2,0,3, 2,1,6, 1,0,0,-1,0,-1,0,0,1));
      vecs.push_back(mk(0,0, 2,0,3, 2,1,6, 0,1,0,-1,0,-1,0,0,1));
    end
    for (int k = 0; k < DEPTH; k++)
      vecs.push_back(mk(0,0, 0,0,0, 2,k,k+1, 0,1,0,-1,0,-1,0,0,1));
    vecs.push_back(mk(0,0, 0,0,0, 1,3,0, 0,1,0,-1,0,-1,0,0,1));
    vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0,-1,1, 4,0,0,0));
    for (int k = 0; k < DEPTH; k++)
      vecs.push_back(mk(0,0, 2,k,7, 0,0,0, 1,0,0,-1,0,-1,0,0,1));
    vecs.push_back(mk(0,0, 0,0,0, 1,1,0, 0,1,0,-1,0,-1,0,0,1));
    vecs.push_back(mk(0,1, 1,0,0, 0,0,0, 0,0,0,-1,1, 7,0,0,0));
    vecs.push_back(mk(0,0, 1,0,0, 0,0,0, 0,0,0,-1,0,-1,1,0,1));
    vecs.push_back(mk(0,1, 1,0,0, 0,0,0, 0,0,0,-1,0,-1,1,0,1));
    vecs.push_back(mk(0,0, 1,0,0, 0,0,0, 0,0,0,-1,0,-1,1,0,1));
    vecs.push_back(mk(0,0, 1,0,0, 0,0,0, 0,0,0,-1,0,-1,1,0,1));
    vecs.push_back(mk(0,0, 1,0,0, 0,0,0, 1,0,0,-1,0,-1,0,1,1));
    for (int k = 1; k < DEPTH; k++)
      vecs.push_back(mk(0,0, 1,k,0, 0,0,0, 1,0,1, 0,0,-1,0,0,1));
    vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,1, 0,0,-1,0,0,0));
    vecs.push_back(mk(0,1, 0,0,0, 0,0,0, 0,0,0,-1,0,-1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0,-1,0,-1,1,0,1));
    vecs.push_back(mk(1,0, 0,0,0, 1,0,0, 0,0,0,-1,0,-1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0, 1,0,0, 0,1,0,-1,0,-1,0,0,1));
    vecs.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0,-1,1,-1,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].op0, vecs[i].a0, vecs[i].d0,
            vecs[i].op1, vecs[i].a1, vecs[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d gnt0", i), int'(gnt0), vecs[i].g0);
      chk($sformatf("v%0d gnt1", i), int'(gnt1), vecs[i].g1);
      chk($sformatf("v%0d qv0", i), int'(qv0), vecs[i].qv0);
      chk($sformatf("v%0d qv1", i), int'(qv1), vecs[i].qv1);
      chk($sformatf("v%0d clr_busy", i), int'(clr_busy), vecs[i].busy);
      chk($sformatf("v%0d clr_done", i), int'(clr_done), vecs[i].done);
      chk($sformatf("v%0d ram_en", i), int'(ram_en), vecs[i].en);
      if (vecs[i].qv0 != 0 && vecs[i].q0 >= 0) chk($sformatf("v%0d q0", i), int'(q0), vecs[i].q0);
      if (vecs[i].qv1 != 0 && vecs[i].q1 >= 0) chk($sformatf("v%0d q1", i), int'(q1), vecs[i].q1);
      @(posedge clk);
      #1;
    end

    // Randomized run: reset, then a forced clear so every address has a known value.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rnd reset gnt0", int'(gnt0), 0);
    chk("rnd reset busy", int'(clr_busy), 0);
    @(posedge clk);
    #1;
    m_prio = 0; m_clear_left = 0; m_done = 0; m_qv0 = 0; m_qv1 = 0; m_q0 = -1; m_q1 = -1;
    for (int k = 0; k < DEPTH; k++) begin m_mem[k] = 0; m_valid[k] = 0; end
    for (int r = 0; r < 2; r++) p_req[r] = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      int clr, win, e_en, e_wr, e_a, e_d;
      for (int r = 0; r < 2; r++) begin
        if (!p_req[r] && $urandom_range(0, 2) != 0) begin
          p_req[r] = 1;
          p_wr[r] = $urandom_range(0, 1) != 0;
          p_a[r] = int'($urandom_range(0, DEPTH-1));
          p_d[r] = int'($urandom_range(0, (1<<DW)-1));
        end
      end
      clr = (cyc == 0 || $urandom_range(0, 39) == 0) ? 1 : 0;
      drive(0, clr, p_req[0] ? (p_wr[0] ? 2 : 1) : 0, p_a[0], p_d[0],
            p_req[1] ? (p_wr[1] ? 2 : 1) : 0, p_a[1], p_d[1]);

      win = -1; e_en = 0; e_wr = 0; e_a = 0; e_d = 0;
      if (m_clear_left > 0) begin
        e_en = 1; e_wr = 1; e_a = DEPTH - m_clear_left; e_d = 0;
      end else if (clr == 0) begin
        if (p_req[0] && p_req[1]) win = m_prio;
        else if (p_req[0]) win = 0;
        else if (p_req[1]) win = 1;
        if (win >= 0) begin
          e_en = 1; e_wr = int'(p_wr[win]); e_a = p_a[win]; e_d = p_d[win];
        end
      end

      @(negedge clk);
      chk("rnd gnt0", int'(gnt0), (win == 0) ? 1 : 0);
      chk("rnd gnt1", int'(gnt1), (win == 1) ? 1 : 0);
      chk("rnd ram_en", int'(ram_en), e_en);
      if (e_en != 0) begin
        chk("rnd ram_wr", int'(ram_wr), e_wr);
        chk("rnd ram_a", int'(ram_a), e_a);
        if (e_wr != 0) chk("rnd ram_d", int'(ram_d), e_d);
      end
      chk("rnd qv0", int'(qv0), int'(m_qv0));
      chk("rnd qv1", int'(qv1), int'(m_qv1));
      if (m_qv0 && m_q0 >= 0) chk("rnd q0", int'(q0), m_q0);
      if (m_qv1 && m_q1 >= 0) chk("rnd q1", int'(q1), m_q1);
      chk("rnd clr_busy", int'(clr_busy), (m_clear_left > 0) ? 1 : 0);
      chk("rnd clr_done", int'(clr_done), m_done);

      @(posedge clk);
      m_done = (m_clear_left == 1) ? 1 : 0;
      m_qv0 = 0;
      m_qv1 = 0;
      if (m_clear_left > 0) begin
        m_mem[e_a] = 0;
        m_valid[e_a] = 1;
        m_clear_left--;
      end else if (clr != 0) begin
        m_clear_left = DEPTH;
      end else if (win >= 0) begin
        if (p_wr[win]) begin
          m_mem[p_a[win]] = p_d[win];
          m_valid[p_a[win]] = 1;
        end else if (win == 0) begin
          m_qv0 = 1;
          m_q0 = m_valid[p_a[0]] ? m_mem[p_a[0]] : -1;
        end else begin
          m_qv1 = 1;
          m_q1 = m_valid[p_a[1]] ? m_mem[p_a[1]] : -1;
        end
        m_prio = 1 - win;
        p_req[win] = 0;
      end
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
